mul_rs_station: RTL and testbench
=================================

// Module: mul_rs_station
// PURPOSE
// Parametrised multiply reservation station plus pipelined multiplier for the Tomasulo core.
// Holds DEPTH multiply ops and snoops the CDB for missing operands.
// Dispatches one ready op per cycle into a LAT-stage multiplier and returns {tag, rd, result} to the CDB arbiter.
// Adds RV32M MUL/MULH/MULHSU/MULHU modes and valid/ready handshakes on issue and result.
// PARAMETERS
// XLEN      32  operand/result width
// DEPTH     8   entries; entry i owns tag TAG_BASE+i
// TAG_W     5   tag width; all-ones = "no tag, data valid"
// TAG_BASE  16  first tag; TAG_BASE+DEPTH-1 < 2**TAG_W-1 (elaboration check)
// LAT       6   multiplier pipeline depth, >=1
// PORTS
// clk        in   1      clock
// rst        in   1      synchronous reset, active-low
// iss_valid  in   1      issue request from decode/FLR
// iss_ready  out  1      a FREE entry exists
// iss_op     in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
// iss_rd     in   5      destination register id
// iss_tag1   in   TAG_W  rs1 producer tag (all-ones: iss_data1 valid)
// iss_data1  in   XLEN   rs1 value
// iss_tag2   in   TAG_W  rs2 producer tag (all-ones: iss_data2 valid)
// iss_data2  in   XLEN   rs2 value
// iss_tag    out  TAG_W  tag allocated on this issue (TAG_BASE+lowest free index)
// cdb_valid  in   1      CDB broadcast valid
// cdb_tag    in   TAG_W  CDB broadcast tag
// cdb_data   in   XLEN   CDB broadcast data
// res_valid  out  1      result valid toward CDB arbiter
// res_ready  in   1      CDB grant
// res_tag    out  TAG_W  tag of the result
// res_rd     out  5      rd of the result
// res_data   out  XLEN   multiply result
// occupancy  out  $clog2(DEPTH+1)  entries not FREE
// BEHAVIOUR
// - Reset (rst==0 at posedge): all entries FREE, pipeline flushed, res_valid=0, res_tag/res_rd/res_data=0,
//   occupancy=0. Reset mid-operation discards all in-flight ops; no result is emitted for them.
// - Entry states: FREE -> WAIT (a tag is pending) or READY (both operands valid) -> EXEC -> FREE.
//   WAIT -> READY when the last pending tag matches the CDB. EXEC -> FREE on the res_valid&&res_ready edge.
//   The tag stays reserved until its result is accepted.
// - Issue: accepted when iss_valid&&iss_ready. iss_tag and iss_ready are combinational from the current state.
//   An entry freed this cycle is not reusable until the next cycle.
// - Operand capture: an operand whose tag is not all-ones waits for cdb_valid && cdb_tag==tag.
//   It then latches cdb_data and sets its tag to all-ones. Every WAIT entry snoops in parallel.
// - Issue-cycle bypass: if cdb_valid and cdb_tag equals iss_tagN in the accept cycle, cdb_data is captured at once.
// - Dispatch: each cycle the lowest-index READY entry enters stage 1 when the pipeline advances.
//   The pipeline advances when the output register is empty or res_ready=1.
//   Otherwise all stages and dispatch stall. A stall never drops or duplicates an op.
// - Latency: op issued with both operands valid in cycle t, no stall -> res_valid in cycle t+1+LAT.
// - Output: res_* is registered and held stable while res_valid&&!res_ready.
// - Arithmetic: full 2*XLEN product of sign/zero-extended operands.
//   MUL = low XLEN bits, signedness-independent. MULH = s*s high. MULHSU = s*u high. MULHU = u*u high.
//   No overflow flags.
// - Simultaneous events: issue, CDB capture, dispatch and result accept may all occur in one cycle.
// TESTING
// - Reset then issue MUL 7*6, tags all-ones, at cycle 0 -> res_valid at cycle 7, res_data=42, res_tag=16, rd echoed.
// - Issue MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*2 -> 0x1; MULHSU -1*2 -> 0xFFFFFFFF.
// - Issue with iss_tag1=3 pending; CDB tag 3 data 5 two cycles later; rs2=9 -> WAIT then READY, result 45.
// - Fill 8 entries -> iss_ready=0, occupancy=8.
//   res_ready held 0 for 10 cycles -> res_* stable, no loss; release -> 8 results in order of dispatch.
// - CDB tag 4 broadcast in the same cycle as an issue with iss_tag2=4 -> operand captured via bypass, result correct.
// - Assert rst mid-execution with 3 ops in flight -> no res_valid afterwards, iss_ready=1, occupancy=0.

Source files
------------

// File: rtl/mul_rs_station.sv
// Multiply reservation station: DEPTH entries snoop the CDB and feed a LAT-stage
// RV32M multiplier whose last stage doubles as the registered result port.

module mul_rs_entry #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             dispatch,
    input  logic             retire,
    input  logic [1:0]       iss_op,
    input  logic [4:0]       iss_rd,
    input  logic [TAG_W-1:0] iss_tag1,
    input  logic [XLEN-1:0]  iss_data1,
    input  logic [TAG_W-1:0] iss_tag2,
    input  logic [XLEN-1:0]  iss_data2,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             is_free,
    output logic             is_ready,
    output logic [1:0]       op,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  data1,
    output logic [XLEN-1:0]  data2
);
    localparam logic [TAG_W-1:0] NO_TAG = '1;

    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} state_t;

    state_t           state;
    logic [TAG_W-1:0] tag1, tag2;
    logic             hit1, hit2, iss_hit1, iss_hit2, done1, done2, iss_done1, iss_done2;

    assign hit1      = cdb_valid && (tag1 != NO_TAG) && (cdb_tag == tag1);
    assign hit2      = cdb_valid && (tag2 != NO_TAG) && (cdb_tag == tag2);
    assign iss_hit1  = cdb_valid && (iss_tag1 != NO_TAG) && (cdb_tag == iss_tag1);
    assign iss_hit2  = cdb_valid && (iss_tag2 != NO_TAG) && (cdb_tag == iss_tag2);
    assign done1     = (tag1 == NO_TAG) || hit1;
    assign done2     = (tag2 == NO_TAG) || hit2;
    assign iss_done1 = (iss_tag1 == NO_TAG) || iss_hit1;
    assign iss_done2 = (iss_tag2 == NO_TAG) || iss_hit2;
    assign is_free   = (state == FREE);
    assign is_ready  = (state == READY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FREE;
            tag1  <= NO_TAG;
            tag2  <= NO_TAG;
            op    <= '0;
            rd    <= '0;
            data1 <= '0;
            data2 <= '0;
        end else begin
            case (state)
                FREE: if (alloc) begin
                    op    <= iss_op;
                    rd    <= iss_rd;
                    // a broadcast landing in the issue cycle is taken directly
                    tag1  <= iss_hit1 ? NO_TAG : iss_tag1;
                    data1 <= iss_hit1 ? cdb_data : iss_data1;
                    tag2  <= iss_hit2 ? NO_TAG : iss_tag2;
                    data2 <= iss_hit2 ? cdb_data : iss_data2;
                    state <= (iss_done1 && iss_done2) ? READY : WAIT;
                end
                WAIT: begin
                    if (hit1) begin
                        tag1  <= NO_TAG;
                        data1 <= cdb_data;
                    end
                    if (hit2) begin
                        tag2  <= NO_TAG;
                        data2 <= cdb_data;
                    end
                    if (done1 && done2) state <= READY;
                end
                READY: if (dispatch) state <= EXEC;
                EXEC:  if (retire) state <= FREE;
                default: state <= FREE;
            endcase
        end
    end
endmodule

module mul_rs_station #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = 5,
    parameter int TAG_BASE = 16,
    parameter int LAT      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic [1:0]                 iss_op,
    input  logic [4:0]                 iss_rd,
    input  logic [TAG_W-1:0]           iss_tag1,
    input  logic [XLEN-1:0]            iss_data1,
    input  logic [TAG_W-1:0]           iss_tag2,
    input  logic [XLEN-1:0]            iss_data2,
    output logic [TAG_W-1:0]           iss_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [4:0]                 res_rd,
    output logic [XLEN-1:0]            res_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    if (TAG_BASE + DEPTH - 1 >= (1 << TAG_W) - 1) begin : g_tag_range_bad
        $error("mul_rs_station: entry tags overlap the all-ones no-tag code");
    end
    if (LAT < 1) begin : g_lat_bad
        $error("mul_rs_station: LAT must be at least 1");
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        logic [XLEN-1:0]  data;
    } res_t;

    logic [DEPTH-1:0]           free_vec, ready_vec, alloc_vec, disp_vec, retire_vec;
    logic [DEPTH-1:0][1:0]      ent_op;
    logic [DEPTH-1:0][4:0]      ent_rd;
    logic [DEPTH-1:0][XLEN-1:0] ent_d1, ent_d2;
    logic [IDX_W-1:0]           free_idx, ready_idx;
    logic [OCC_W-1:0]           occ;
    logic                       accept, advance, disp;
    logic [LAT:1]               vld_pipe;
    res_t                       pipe [1:LAT];
    res_t                       disp_res;
    logic [XLEN-1:0]            opa, opb;
    logic                       sa, sb;
    logic [2*XLEN-1:0]          a_ext, b_ext, prod;

    always_comb begin
        free_idx  = '0;
        ready_idx = '0;
        occ       = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (free_vec[i])  free_idx  = IDX_W'(i);
            if (ready_vec[i]) ready_idx = IDX_W'(i);
            occ = occ + OCC_W'(!free_vec[i]);
        end
    end

    assign iss_ready = |free_vec;
    assign iss_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign occupancy = occ;
    assign accept    = iss_valid && iss_ready;
    // the output register is the last stage, so only it can hold the pipe back
    assign advance   = !vld_pipe[LAT] || res_ready;
    assign disp      = advance && |ready_vec;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign alloc_vec[i]  = accept && (free_idx == IDX_W'(i));
        assign disp_vec[i]   = disp && (ready_idx == IDX_W'(i));
        assign retire_vec[i] = res_valid && res_ready && (res_tag == TAG_W'(TAG_BASE + i));

        mul_rs_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_ent (
            .clk       (clk),
            .rst       (rst),
            .alloc     (alloc_vec[i]),
            .dispatch  (disp_vec[i]),
            .retire    (retire_vec[i]),
            .iss_op    (iss_op),
            .iss_rd    (iss_rd),
            .iss_tag1  (iss_tag1),
            .iss_data1 (iss_data1),
            .iss_tag2  (iss_tag2),
            .iss_data2 (iss_data2),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .is_free   (free_vec[i]),
            .is_ready  (ready_vec[i]),
            .op        (ent_op[i]),
            .rd        (ent_rd[i]),
            .data1     (ent_d1[i]),
            .data2     (ent_d2[i])
        );
    end

    // 2*XLEN-bit product of sign/zero-extended operands; retiming spreads it over the stages
    always_comb begin
        opa           = ent_d1[ready_idx];
        opb           = ent_d2[ready_idx];
        sa            = (ent_op[ready_idx] == 2'b01) || (ent_op[ready_idx] == 2'b10);
        sb            = (ent_op[ready_idx] == 2'b01);
        a_ext         = {{XLEN{sa & opa[XLEN-1]}}, opa};
        b_ext         = {{XLEN{sb & opb[XLEN-1]}}, opb};
        prod          = a_ext * b_ext;
        disp_res.tag  = TAG_W'(TAG_BASE) + TAG_W'(ready_idx);
        disp_res.rd   = ent_rd[ready_idx];
        disp_res.data = (ent_op[ready_idx] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int k = 1; k <= LAT; k++) pipe[k] <= '0;
        end else if (advance) begin
            vld_pipe[1] <= disp;
            pipe[1]     <= disp_res;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                pipe[k]     <= pipe[k-1];
            end
        end
    end

    assign res_valid = vld_pipe[LAT];
    assign res_tag   = pipe[LAT].tag;
    assign res_rd    = pipe[LAT].rd;
    assign res_data  = pipe[LAT].data;
endmodule

// File: tb/tb_mul_rs_station.sv
// Directed bench for mul_rs_station: latency, RV32M modes, CDB wake-up, bypass,
// full-station backpressure and mid-flight reset.

module tb_mul_rs_station;
    localparam logic [4:0] NT = 5'h1F;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready;
    logic [1:0]  iss_op;
    logic [4:0]  iss_rd, iss_tag1, iss_tag2, iss_tag;
    logic [31:0] iss_data1, iss_data2;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        res_valid, res_ready;
    logic [4:0]  res_tag, res_rd;
    logic [31:0] res_data;
    logic [3:0]  occupancy;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    mul_rs_station dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rd(iss_rd),
        .iss_tag1(iss_tag1), .iss_data1(iss_data1), .iss_tag2(iss_tag2), .iss_data2(iss_data2),
        .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_rd(res_rd),
        .res_data(res_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] t1,
                         input logic [31:0] d1, input logic [4:0] t2, input logic [31:0] d2);
        iss_valid = 1'b1; iss_op = op; iss_rd = rd;
        iss_tag1 = t1; iss_data1 = d1; iss_tag2 = t2; iss_data2 = d2;
        @(negedge clk);
        iss_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit, output logic got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            if (res_valid) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_chk++; if (res_tag !== 5'd0) begin n_fail++; $display("FAIL reset_res_tag: got %0d expected 0", res_tag); end
        n_chk++; if (res_rd !== 5'd0) begin n_fail++; $display("FAIL reset_res_rd: got %0d expected 0", res_rd); end
        n_chk++; if (res_data !== 32'd0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        n_chk++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_chk++; if (iss_ready !== 1'b1 || iss_tag !== 5'd16) begin n_fail++; $display("FAIL reset_iss: got ready=%b tag=%0d expected ready=1 tag=16", iss_ready, iss_tag); end
    endtask

    task automatic test_mul_basic();
        int c0; logic got;
        c0 = cyc;
        issue(2'b00, 5'd3, NT, 32'd7, NT, 32'd6);
        wait_res(20, got);
        n_chk++; if (!got || cyc - c0 != 7) begin n_fail++; $display("FAIL basic_latency: got %0d cycles (seen=%b) expected 7", cyc - c0, got); end
        n_chk++; if (res_data !== 32'd42) begin n_fail++; $display("FAIL basic_data: got %0d expected 42", res_data); end
        n_chk++; if (res_tag !== 5'd16) begin n_fail++; $display("FAIL basic_tag: got %0d expected 16", res_tag); end
        n_chk++; if (res_rd !== 5'd3) begin n_fail++; $display("FAIL basic_rd: got %0d expected 3", res_rd); end
        @(negedge clk);
    endtask

    task automatic test_modes();
        logic [1:0]  ops [8] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
        logic [31:0] va  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] vb  [8] = '{32'h80000000, 32'd2, 32'd2, 32'h80000000,
                                 32'd5, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] ex  [8] = '{32'h40000000, 32'h1, 32'hFFFFFFFF, 32'hC0000000,
                                 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h3FFFFFFF};
        logic got;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], 5'(i + 8), NT, va[i], NT, vb[i]);
            wait_res(20, got);
            n_chk++;
            if (!got || res_data !== ex[i] || res_rd !== 5'(i + 8))
                begin n_fail++; $display("FAIL mode_%0d: got seen=%b data=%h rd=%0d expected data=%h rd=%0d", i, got, res_data, res_rd, ex[i], i + 8); end
            @(negedge clk);
        end
    endtask

    task automatic test_cdb_wait();
        int c0; logic got;
        c0 = cyc;
        issue(2'b00, 5'd5, 5'd3, 32'hBAD0BAD0, NT, 32'd9);
        n_chk++; if (occupancy !== 4'd1 || iss_tag !== 5'd17) begin n_fail++; $display("FAIL wait_state: got occ=%0d iss_tag=%0d expected occ=1 iss_tag=17", occupancy, iss_tag); end
        @(negedge clk);
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'd5;
        @(negedge clk);
        cdb_valid = 1'b0;
        wait_res(30, got);
        n_chk++; if (!got || cyc - c0 != 9) begin n_fail++; $display("FAIL wait_latency: got %0d cycles (seen=%b) expected 9", cyc - c0, got); end
        n_chk++; if (res_data !== 32'd45 || res_tag !== 5'd16) begin n_fail++; $display("FAIL wait_result: got data=%0d tag=%0d expected 45/16", res_data, res_tag); end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        int c0; logic got;
        c0 = cyc;
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'd3;
        issue(2'b00, 5'd2, NT, 32'd11, 5'd4, 32'h0000DEAD);
        cdb_valid = 1'b0;
        wait_res(20, got);
        n_chk++; if (!got || cyc - c0 != 7) begin n_fail++; $display("FAIL bypass_latency: got %0d cycles (seen=%b) expected 7", cyc - c0, got); end
        n_chk++; if (res_data !== 32'd33 || res_rd !== 5'd2) begin n_fail++; $display("FAIL bypass_result: got data=%0d rd=%0d expected 33/2", res_data, res_rd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (iss_ready !== 1'b1 || iss_tag !== 5'(16 + i)) begin n_fail++; $display("FAIL fill_tag_%0d: got ready=%b tag=%0d expected ready=1 tag=%0d", i, iss_ready, iss_tag, 16 + i); end
            issue(2'b00, 5'(i), NT, 32'(i + 1), NT, 32'd10);
        end
        n_chk++; if (iss_ready !== 1'b0 || occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_full: got ready=%b occ=%0d expected 0/8", iss_ready, occupancy); end
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if ({res_valid, res_tag, res_data} !== {1'b1, 5'd16, 32'd10} || iss_ready !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold_%0d: got v=%b tag=%0d data=%0d ready=%b expected 1/16/10/0", c, res_valid, res_tag, res_data, iss_ready); end
            @(negedge clk);
        end
        res_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (res_valid) begin
                n_chk++;
                if (res_tag !== 5'(16 + k) || res_data !== 32'((k + 1) * 10) || res_rd !== 5'(k))
                    begin n_fail++; $display("FAIL drain_%0d: got tag=%0d data=%0d rd=%0d expected %0d/%0d/%0d", k, res_tag, res_data, res_rd, 16 + k, (k + 1) * 10, k); end
                k++;
            end
            @(negedge clk);
        end
        n_chk++; if (k != 8) begin n_fail++; $display("FAIL drain_count: got %0d results expected 8", k); end
        n_chk++; if (occupancy !== 4'd0 || iss_ready !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got occ=%0d ready=%b expected 0/1", occupancy, iss_ready); end
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int i = 0; i < 3; i++) issue(2'b00, 5'(20 + i), NT, 32'd7, NT, 32'd6);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (occupancy !== 4'd3) begin n_fail++; $display("FAIL mid_inflight: got occ=%0d expected 3", occupancy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_chk++; if (occupancy !== 4'd0 || iss_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state: got occ=%0d ready=%b expected 0/1", occupancy, iss_ready); end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_result: got %0d res_valid cycles expected 0", seen); end
    endtask

    initial begin
        rst = 1'b0; iss_valid = 1'b0; iss_op = 2'b00; iss_rd = 5'd0;
        iss_tag1 = NT; iss_data1 = '0; iss_tag2 = NT; iss_data2 = '0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_data = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_mul_basic();
        test_modes();
        test_cdb_wait();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
